// File: rtl/sblk_pkg.sv
// sblk_pkg: shared types and default widths for the SuperBlock job sequencer.
// PIPE_LAT follows the cascaded-DSP depth of N_TILE supertiles.
package sblk_pkg;

    localparam int N_TILE       = 4;
    localparam int WID_WADDR    = 10;
    localparam int WID_ACTADDR  = 6;
    localparam int WID_PSUMADDR = 9;

    function automatic int pipe_lat(input int n_tile);
        return n_tile + 4;
    endfunction

    localparam int PIPE_LAT = pipe_lat(N_TILE);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [WID_PSUMADDR:0]  n_out;
        logic [WID_ACTADDR-2:0] n_pass;
        logic                   acc_clr;
    } cmd_t;

endpackage

// File: rtl/sblk_ctrl_wbpipe.sv
// sblk_ctrl_wbpipe: DEPTH-stage {valid,addr} delay line matching the
// DSP cascade latency; clr drops every in-flight entry.
module sblk_ctrl_wbpipe #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic          clk_h,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);
    import sblk_pkg::*;

    logic [DEPTH-1:0] v_q;
    logic [AW-1:0]    a_q [DEPTH];

    always_ff @(posedge clk_h) begin
        if (clr) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            v_q    <= {v_q[DEPTH-2:0], in_valid};
            a_q[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                a_q[i] <= a_q[i-1];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_addr  = a_q[DEPTH-1];

endmodule

// File: rtl/sblk_ctrl.sv
// sblk_ctrl: per-job address/strobe sequencer for one SuperBlock.
// Optional SBLK_CTRL_PERF_EN adds RUN/GAP cycle counters.
module sblk_ctrl #(
    parameter int N_TILE       = sblk_pkg::N_TILE,
    parameter int WID_WADDR    = sblk_pkg::WID_WADDR,
    parameter int WID_ACTADDR  = sblk_pkg::WID_ACTADDR,
    parameter int WID_PSUMADDR = sblk_pkg::WID_PSUMADDR
) (
    input  logic                    clk_h,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WID_PSUMADDR:0]   cmd_n_out,
    input  logic [WID_ACTADDR-2:0]  cmd_n_pass,
    input  logic                    cmd_acc_clr,
    output logic [WID_WADDR-1:0]    w_rd_addr,
    output logic [WID_ACTADDR-2:0]  act_rd_addr_hbit,
    output logic [WID_PSUMADDR-1:0] psum_rd_addr,
    output logic                    psum_zero,
    output logic [WID_PSUMADDR-1:0] psum_wr_addr,
    output logic                    psum_wr_en,
    output logic                    busy,
    output logic                    done
`ifdef SBLK_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_run_cyc,
    output logic [31:0]             perf_stall_cyc
`endif
);
    import sblk_pkg::*;

    localparam int OW = WID_PSUMADDR + 1;
    localparam int PL = pipe_lat(N_TILE);
    localparam logic [OW-1:0] PL_W = OW'(PL);

    state_e state_q, state_d;
    cmd_t   cmd_q;

    logic [OW-1:0]          o_q;
    logic [OW-1:0]          cyc_q;
    logic [OW-1:0]          n_norm;
    logic [WID_ACTADDR-2:0] p_q;
    logic [WID_WADDR-1:0]   w_q;
    logic                   issue;
    logic                   last_o;
    logic                   last_p;
    logic                   wb_v;
    logic [OW-1:0]          wb_o;

    // Psums travel in pairs, so odd counts round down; zero means one pair.
    always_comb begin
        n_norm = cmd_n_out & ~OW'(1);
        if (n_norm == '0) begin
            n_norm = OW'(2);
        end
    end

    assign last_o = (o_q == cmd_q.n_out - OW'(1));
    assign last_p = (p_q == cmd_q.n_pass);

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = RUN;
            end
            RUN: begin
                issue = 1'b1;
                if (last_o) begin
                    if (last_p) state_d = DRAIN;
                    else if (cmd_q.n_out < PL_W) state_d = GAP;
                end
            end
            GAP: begin
                if (cyc_q == OW'(1)) state_d = RUN;
            end
            DRAIN: begin
                if (cyc_q == OW'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            o_q     <= '0;
            p_q     <= '0;
            w_q     <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.n_out   <= n_norm;
                        cmd_q.n_pass  <= cmd_n_pass;
                        cmd_q.acc_clr <= cmd_acc_clr;
                        o_q <= '0;
                        p_q <= '0;
                        w_q <= '0;
                    end
                end
                RUN: begin
                    w_q <= w_q + WID_WADDR'(1);
                    o_q <= last_o ? '0 : o_q + OW'(1);
                    if (last_o) begin
                        cyc_q <= last_p ? PL_W : PL_W - cmd_q.n_out;
                    end
                    if (last_o && state_d == RUN) begin
                        p_q <= p_q + (WID_ACTADDR-1)'(1);
                    end
                end
                GAP: begin
                    cyc_q <= cyc_q - OW'(1);
                    if (state_d == RUN) begin
                        p_q <= p_q + (WID_ACTADDR-1)'(1);
                    end
                end
                DRAIN: cyc_q <= cyc_q - OW'(1);
                default: ;
            endcase
        end
    end

    assign w_rd_addr        = w_q;
    assign act_rd_addr_hbit = p_q;
    assign psum_rd_addr     = o_q[OW-1:1];
    assign psum_zero        = issue && cmd_q.acc_clr && (p_q == '0);

    sblk_ctrl_wbpipe #(
        .DEPTH (PL),
        .AW    (OW)
    ) u_wbpipe (
        .clk_h     (clk_h),
        .clr       (rst),
        .in_valid  (issue),
        .in_addr   (o_q),
        .out_valid (wb_v),
        .out_addr  (wb_o)
    );

    // A word is written once its odd (second) psum retires.
    assign psum_wr_en   = wb_v && wb_o[0];
    assign psum_wr_addr = wb_o[OW-1:1];

`ifdef SBLK_CTRL_PERF_EN
    always_ff @(posedge clk_h) begin
        if (rst || (state_q == IDLE && cmd_valid)) begin
            perf_run_cyc   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (state_q == RUN && !(&perf_run_cyc)) begin
                perf_run_cyc <= perf_run_cyc + 32'd1;
            end
            if (state_q == GAP && !(&perf_stall_cyc)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sblk_ctrl.sv
// tb_sblk_ctrl: directed jobs checked cycle-by-cycle against a job-level
// model of the sequencer, plus literal write counts and done latencies.
module tb_sblk_ctrl;
    import sblk_pkg::*;

    localparam int PL = pipe_lat(N_TILE);

    logic        clk_h = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_n_out = '0;
    logic [4:0]  cmd_n_pass = '0;
    logic        cmd_acc_clr = 1'b0;
    logic [9:0]  w_rd_addr;
    logic [4:0]  act_rd_addr_hbit;
    logic [8:0]  psum_rd_addr;
    logic        psum_zero;
    logic [8:0]  psum_wr_addr;
    logic        psum_wr_en;
    logic        busy;
    logic        done;
`ifdef SBLK_CTRL_PERF_EN
    logic [31:0] perf_run_cyc;
    logic [31:0] perf_stall_cyc;
`endif

    sblk_ctrl dut (
        .clk_h            (clk_h),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_n_out        (cmd_n_out),
        .cmd_n_pass       (cmd_n_pass),
        .cmd_acc_clr      (cmd_acc_clr),
        .w_rd_addr        (w_rd_addr),
        .act_rd_addr_hbit (act_rd_addr_hbit),
        .psum_rd_addr     (psum_rd_addr),
        .psum_zero        (psum_zero),
        .psum_wr_addr     (psum_wr_addr),
        .psum_wr_en       (psum_wr_en),
        .busy             (busy),
        .done             (done)
`ifdef SBLK_CTRL_PERF_EN
        ,
        .perf_run_cyc     (perf_run_cyc),
        .perf_stall_cyc   (perf_stall_cyc)
`endif
    );

    always #5 clk_h = ~clk_h;

    int tcyc = 0;
    always @(posedge clk_h) tcyc <= tcyc + 1;

    typedef struct {
        bit issue;
        bit ready;
        bit busy;
        bit done;
        bit zero;
        bit wr_en;
        bit rstz;
        int w;
        int hbit;
        int rd;
        int wr_addr;
    } exp_t;

    exp_t m [256];
    int   t0, chk_from, chk_last, job_id;
    int   lit_wr, lit_done, exp_run, exp_stall;
    bit   chk_en = 1'b0;
    bit   rst_chk = 1'b0;

    int checks = 0;
    int errors = 0;
    int rel, obs_wr, obs_done;
    int seen_id = 0;

    task automatic chk(input string nm, input int r,
                       input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s rel=%0d got=%0d want=%0d",
                     nm, r, got, want);
        end
    endtask

    always @(negedge clk_h) begin
        if (rst_chk) begin
            chk("rst_ready", 0, cmd_ready, 1);
            chk("rst_busy", 0, busy, 0);
            chk("rst_done", 0, done, 0);
            chk("rst_wr_en", 0, psum_wr_en, 0);
            chk("rst_w", 0, w_rd_addr, 0);
            chk("rst_zero", 0, psum_zero, 0);
            chk("rst_rd", 0, psum_rd_addr, 0);
            chk("rst_hbit", 0, act_rd_addr_hbit, 0);
            chk("rst_wr_addr", 0, psum_wr_addr, 0);
        end
        if (chk_en) begin
            rel = tcyc - t0;
            if (job_id != seen_id) begin
                seen_id  = job_id;
                obs_wr   = 0;
                obs_done = -1;
            end
            if (rel >= chk_from && rel <= chk_last) begin
                if (psum_wr_en) obs_wr++;
                if (done && obs_done < 0) obs_done = rel;
                chk("ready", rel, cmd_ready, m[rel].ready);
                chk("busy", rel, busy, m[rel].busy);
                chk("done", rel, done, m[rel].done);
                chk("wr_en", rel, psum_wr_en, m[rel].wr_en);
                if (m[rel].wr_en)
                    chk("wr_addr", rel, psum_wr_addr, m[rel].wr_addr);
                if (m[rel].issue) begin
                    chk("w_addr", rel, w_rd_addr, m[rel].w);
                    chk("hbit", rel, act_rd_addr_hbit, m[rel].hbit);
                    chk("rd_addr", rel, psum_rd_addr, m[rel].rd);
                    chk("zero", rel, psum_zero, m[rel].zero);
                end
                if (m[rel].rstz) begin
                    chk("rz_w", rel, w_rd_addr, 0);
                    chk("rz_hbit", rel, act_rd_addr_hbit, 0);
                    chk("rz_zero", rel, psum_zero, 0);
                    chk("rz_wr_addr", rel, psum_wr_addr, 0);
                end
                if (rel == chk_last) begin
                    chk("n_writes", rel, obs_wr, lit_wr);
                    chk("done_rel", rel, obs_done, lit_done);
`ifdef SBLK_CTRL_PERF_EN
                    chk("perf_run", rel, perf_run_cyc, exp_run);
                    chk("perf_stall", rel, perf_stall_cyc, exp_stall);
`endif
                end
            end
        end
    end

    task automatic run_job(input int n_raw, input int np,
                           input bit clr, input bit hold,
                           input bit chained, input int abort_after,
                           input int lw, input int ld);
        int n, t, w, first_wr, ab, last;
        for (int i = 0; i < 256; i++) m[i] = '{default: 0};
        n = n_raw & ~1;
        if (n == 0) n = 2;
        t = 1;
        w = 0;
        first_wr = -1;
        ab = -1;
        for (int p = 0; p <= np; p++) begin
            for (int o = 0; o < n; o++) begin
                m[t].issue = 1'b1;
                m[t].w     = w % 1024;
                m[t].hbit  = p;
                m[t].rd    = o / 2;
                m[t].zero  = clr && (p == 0);
                if (o % 2 == 1) begin
                    m[t+PL].wr_en   = 1'b1;
                    m[t+PL].wr_addr = o / 2;
                    if (first_wr < 0) first_wr = t + PL;
                end
                t++;
                w++;
            end
            if (p < np && n < PL) t += PL - n;
        end
        t += PL;
        m[t].done = 1'b1;
        for (int i = 1; i <= t; i++) m[i].busy = 1'b1;
        m[0].ready   = 1'b1;
        m[t+1].ready = 1'b1;
        last = t + 1;
        exp_run   = n * (np + 1);
        exp_stall = (n < PL) ? np * (PL - n) : 0;
        if (abort_after >= 0) begin
            ab = first_wr + abort_after;
            for (int i = ab + 1; i <= ab + t; i++) begin
                m[i] = '{default: 0};
                m[i].ready = 1'b1;
                m[i].rstz  = 1'b1;
            end
            last = ab + t;
            exp_run   = 0;
            exp_stall = 0;
        end
        job_id++;
        lit_wr   = lw;
        lit_done = ld;
        chk_from = chained ? 1 : 0;
        chk_last = last;
        t0 = chained ? tcyc - 1 : tcyc;
        if (!chained) begin
            cmd_n_out   = 10'(n_raw);
            cmd_n_pass  = 5'(np);
            cmd_acc_clr = clr;
            cmd_valid   = 1'b1;
        end else begin
            cmd_valid = hold;
        end
        chk_en = 1'b1;
        for (int c = chk_from; c <= last; c++) begin
            rst = (abort_after >= 0) && (c == ab);
            @(posedge clk_h);
            #2;
            if (!hold) cmd_valid = 1'b0;
        end
        rst    = 1'b0;
        chk_en = 1'b0;
    endtask

    initial begin
        job_id = 0;
        repeat (3) @(posedge clk_h);
        #2;
        rst = 1'b0;
        rst_chk = 1'b1;
        @(posedge clk_h);
        #2;
        rst_chk = 1'b0;

        run_job(8, 0, 1'b1, 1'b0, 1'b0, -1, 4, 17);
        run_job(4, 2, 1'b0, 1'b0, 1'b0, -1, 6, 29);
        run_job(20, 1, 1'b1, 1'b0, 1'b0, -1, 20, 49);
        run_job(8, 1, 1'b0, 1'b0, 1'b0, -1, 8, 25);
        run_job(6, 0, 1'b0, 1'b1, 1'b0, -1, 3, 15);
        run_job(6, 0, 1'b0, 1'b0, 1'b1, -1, 3, 15);
        run_job(8, 0, 1'b1, 1'b0, 1'b0, 3, 2, -1);
        run_job(5, 0, 1'b0, 1'b0, 1'b0, -1, 2, 13);
        run_job(0, 1, 1'b1, 1'b0, 1'b0, -1, 2, 19);

        repeat (2) @(posedge clk_h);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
